// File: rtl/l1_dcache_pkg.sv
// Shared LC-3b types for the L1 data cache slice.
package l1_dcache_pkg;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_datbus;
  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;

  localparam int OFF_BITS  = 4;   // 16-byte lines
  localparam int LINE_BITS = 16 - OFF_BITS;
endpackage

// File: rtl/l1_dcache_if.sv
// CPU-side and lower-memory-side signals of the L1 data cache.
interface l1_dcache_if;
  import l1_dcache_pkg::*;

  logic       dcache_mem_req;
  logic       dcache_we_on_req;
  lc3b_word   dcache_addr;
  lc3b_datbus dcache_wdata;
  lc3b_word   dcache_byte_en;
  logic       dcache_resp;
  lc3b_datbus dcache_rdata;
  lc3b_word   pmem_address;
  logic       pmem_read;
  logic       pmem_write;
  lc3b_datbus pmem_wdata;
  lc3b_datbus pmem_rdata;
  logic       pmem_resp;

  // environment side: CPU requester plus lower memory
  modport master (
    output dcache_mem_req, dcache_we_on_req, dcache_addr, dcache_wdata, dcache_byte_en,
    input  dcache_resp, dcache_rdata,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  // cache side
  modport slave (
    input  dcache_mem_req, dcache_we_on_req, dcache_addr, dcache_wdata, dcache_byte_en,
    output dcache_resp, dcache_rdata,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_dcache_array.sv
// Direct-mapped storage: valid/dirty bits (reset), tag and data (not reset).
// Async read of the indexed line, sync byte-masked write.
module dcache_array
  import l1_dcache_pkg::*;
#(
  parameter int IDX_BITS = 3,
  parameter int TAG_BITS = 12 - IDX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] idx,
  input  lc3b_word            data_we,
  input  lc3b_datbus          data_in,
  input  logic                tag_we,
  input  logic [TAG_BITS-1:0] tag_in,
  input  logic                dirty_we,
  input  logic                dirty_in,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_BITS-1:0] tag,
  output lc3b_datbus          data
);
  localparam int LINES = 1 << IDX_BITS;

  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [15:0][7:0]    data_q [LINES];

  // status bits; a tag write always marks the line valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (tag_we)   valid_q[idx] <= 1'b1;
      if (dirty_we) dirty_q[idx] <= dirty_in;
    end
  end

  // tag store
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[idx] <= tag_in;
  end

  // data store, one enable per byte lane
  always_ff @(posedge clk) begin
    for (int b = 0; b < 16; b++)
      if (data_we[b]) data_q[idx][b] <= data_in[8*b +: 8];
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign data  = data_q[idx];
endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back / write-allocate L1 data cache.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int IDX_BITS = 3
) (
  input logic       clk,
  input logic       rst_n,
  l1_dcache_if.slave bus
);
  localparam int TAG_BITS = LINE_BITS - IDX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

  state_e                state, state_nxt;
  logic [LINE_BITS-1:0]  miss_line, line;
  logic [IDX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   atag, c_tag;
  logic                  c_valid, c_dirty, hit;
  lc3b_datbus            c_data, data_in;
  lc3b_word              data_we, pmem_address;
  logic                  tag_we, dirty_we, dirty_in;
  logic                  resp, pmem_read, pmem_write;
  logic                  unused_off;

  // Outside IDLE the line captured at the miss is used, so a request that
  // drops mid-miss still completes its transfer on the original line.
  assign line       = (state == IDLE) ? bus.dcache_addr[15:4] : miss_line;
  assign idx        = line[IDX_BITS-1:0];
  assign atag       = line[LINE_BITS-1:IDX_BITS];
  assign hit        = c_valid && (c_tag == atag);
  assign unused_off = ^bus.dcache_addr[3:0];

  dcache_array #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .idx     (idx),
    .data_we (data_we),
    .data_in (data_in),
    .tag_we  (tag_we),
    .tag_in  (atag),
    .dirty_we(dirty_we),
    .dirty_in(dirty_in),
    .valid   (c_valid),
    .dirty   (c_dirty),
    .tag     (c_tag),
    .data    (c_data)
  );

  // state register and miss-line capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      miss_line <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.dcache_mem_req && !hit) miss_line <= bus.dcache_addr[15:4];
    end
  end

  // next state, handshake outputs and array write controls
  always_comb begin
    state_nxt    = state;
    resp         = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {line, 4'h0};
    data_we      = '0;
    data_in      = bus.dcache_wdata;
    tag_we       = 1'b0;
    dirty_we     = 1'b0;
    dirty_in     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dcache_mem_req) begin
          if (hit) begin
            resp = 1'b1;
            if (bus.dcache_we_on_req) begin
              data_we  = bus.dcache_byte_en;
              dirty_we = 1'b1;
              dirty_in = 1'b1;
            end
          end else begin
            state_nxt = c_dirty ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {c_tag, idx, 4'h0};
        if (bus.pmem_resp) begin
          dirty_we  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          data_we   = '1;
          data_in   = bus.pmem_rdata;
          tag_we    = 1'b1;
          dirty_we  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dcache_resp  = resp;
  assign bus.dcache_rdata = c_data;
  assign bus.pmem_address = pmem_address;
  assign bus.pmem_read    = pmem_read;
  assign bus.pmem_write   = pmem_write;
  assign bus.pmem_wdata   = c_data;
endmodule

// File: tb/tb_l1_dcache.sv
// Bench for l1_dcache: directed vector table, hand-written corner sequences,
// and a random stream checked against an architectural memory model.
module tb_l1_dcache;
  import l1_dcache_pkg::*;

  localparam int LAT = 2;  // lower-memory cycles from request to pmem_resp
  localparam lc3b_datbus AA     = {16{8'hAA}};
  localparam lc3b_datbus W1234  = {8{16'h1234}};
  localparam lc3b_datbus MERGED = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_1234AAAA;
  localparam lc3b_datbus L12    = {8{16'h000C}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1_dcache_if bus();
  l1_dcache #(.IDX_BITS(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic auto_resp = 1'b0, manual_resp = 1'b0;
  assign bus.pmem_resp = auto_resp | manual_resp;

  lc3b_datbus mem     [4096];  // lower memory contents
  lc3b_datbus ref_mem [4096];  // architectural view seen by the CPU
  int tests = 0, fails = 0;
  int fills = 0, wbs = 0, cnt = 0;
  lc3b_word   last_fill_addr = '0, last_wb_addr = '0;
  lc3b_datbus last_wb_data = '0;
  bit both_seen = 1'b0;

  typedef struct { bit is_read; lc3b_datbus exp; } sb_t;
  sb_t sbq[$];

  typedef struct {
    lc3b_word addr; bit we; lc3b_datbus wdata; lc3b_word be;
    int lat; bit chk; lc3b_datbus rdata; int dfill; int dwb;
  } vec_t;
  vec_t vt[5];

  // lower-memory model: responds LAT cycles after a request, on the falling edge
  always @(negedge clk) begin
    if (bus.pmem_read && bus.pmem_write) both_seen = 1'b1;
    auto_resp = 1'b0;
    if (!rst_n) cnt = 0;
    else if (bus.pmem_read || bus.pmem_write) begin
      cnt++;
      if (cnt == LAT) begin
        cnt = 0;
        auto_resp = 1'b1;
        if (bus.pmem_write) begin
          mem[bus.pmem_address[15:4]] = bus.pmem_wdata;
          wbs++;
          last_wb_addr = bus.pmem_address;
          last_wb_data = bus.pmem_wdata;
        end else begin
          bus.pmem_rdata = mem[bus.pmem_address[15:4]];
          fills++;
          last_fill_addr = bus.pmem_address;
        end
      end
    end else cnt = 0;
  end

  task automatic check(input string name, input lc3b_datbus act, input lc3b_datbus exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic ref_write(input lc3b_word a, input lc3b_datbus wd, input lc3b_word be);
    for (int b = 0; b < 16; b++)
      if (be[b]) ref_mem[a[15:4]][8*b +: 8] = wd[8*b +: 8];
  endtask

  // issue one request at #1 after a rising edge; expected data goes through the scoreboard
  task automatic do_req(input lc3b_word a, input bit we, input lc3b_datbus wd,
                        input lc3b_word be, input bit chk, input lc3b_datbus exp,
                        output int lat);
    sb_t e;
    e.is_read = chk;
    e.exp     = exp;
    sbq.push_back(e);
    bus.dcache_addr      = a;
    bus.dcache_we_on_req = we;
    bus.dcache_wdata     = wd;
    bus.dcache_byte_en   = be;
    bus.dcache_mem_req   = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!bus.dcache_resp && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    e = sbq.pop_front();
    if (!bus.dcache_resp) begin
      tests++;
      fails++;
      $display("FAIL resp timeout addr %h", a);
    end else if (e.is_read) check($sformatf("rdata @%h", a), bus.dcache_rdata, e.exp);
    @(posedge clk);
    #1;
    bus.dcache_mem_req = 1'b0;
  endtask

  task automatic wait_pmem_read(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.pmem_read && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.pmem_read) begin
      tests++;
      fails++;
      $display("FAIL %s: pmem_read never asserted", name);
    end
  endtask

  initial begin
    int lat, f0, w0, rc;
    lc3b_word a;
    lc3b_datbus wd;
    lc3b_word be;
    bit we;

    for (int i = 0; i < 4096; i++) mem[i] = {8{4'h0, 12'(i)}};
    mem[4] = AA;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

    vt[0] = '{16'h0040, 1'b0, '0,    16'h0000, LAT+1,   1'b1, AA,     1, 0};
    vt[1] = '{16'h0046, 1'b0, '0,    16'h0000, 0,       1'b1, AA,     0, 0};
    vt[2] = '{16'h0042, 1'b1, W1234, 16'h000C, 0,       1'b0, '0,     0, 0};
    vt[3] = '{16'h004E, 1'b0, '0,    16'hFFFF, 0,       1'b1, MERGED, 0, 0};
    vt[4] = '{16'h00C0, 1'b0, '0,    16'h0000, 2*LAT+1, 1'b1, L12,    1, 1};

    // reset: a pending request must not complete and no memory traffic may start
    bus.dcache_mem_req   = 1'b1;
    bus.dcache_we_on_req = 1'b0;
    bus.dcache_addr      = 16'h0040;
    bus.dcache_wdata     = '0;
    bus.dcache_byte_en   = '0;
    repeat (2) @(negedge clk);
    check("reset resp", 128'(bus.dcache_resp), 128'(0));
    check("reset pmem_read", 128'(bus.pmem_read), 128'(0));
    check("reset pmem_write", 128'(bus.pmem_write), 128'(0));
    bus.dcache_mem_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors: miss, hit, partial write, merged read, dirty eviction
    for (int i = 0; i < 5; i++) begin
      f0 = fills;
      w0 = wbs;
      if (vt[i].we) ref_write(vt[i].addr, vt[i].wdata, vt[i].be);
      do_req(vt[i].addr, vt[i].we, vt[i].wdata, vt[i].be, vt[i].chk, vt[i].rdata, lat);
      check($sformatf("vec%0d latency", i), 128'(lat), 128'(vt[i].lat));
      check($sformatf("vec%0d fills", i), 128'(fills - f0), 128'(vt[i].dfill));
      check($sformatf("vec%0d writebacks", i), 128'(wbs - w0), 128'(vt[i].dwb));
    end
    check("wb addr", 128'(last_wb_addr), 128'(16'h0040));
    check("wb data", last_wb_data, MERGED);
    check("fill addr", 128'(last_fill_addr), 128'(16'h00C0));

    // write hit with no byte enables still dirties the line
    do_req(16'h00C4, 1'b1, W1234, 16'h0000, 1'b0, '0, lat);
    check("be0 write latency", 128'(lat), 128'(0));
    w0 = wbs;
    do_req(16'h0040, 1'b0, '0, '0, 1'b1, ref_mem[4], lat);
    check("be0 evict latency", 128'(lat), 128'(2*LAT+1));
    check("be0 evict writebacks", 128'(wbs - w0), 128'(1));
    check("be0 evict data", last_wb_data, L12);

    // stray pmem_resp in IDLE changes nothing
    manual_resp = 1'b1;
    @(posedge clk);
    #1;
    manual_resp = 1'b0;
    do_req(16'h0048, 1'b0, '0, '0, 1'b1, MERGED, lat);
    check("stray resp hit latency", 128'(lat), 128'(0));

    // request dropped mid-fill: fill finishes silently, line is then resident
    bus.dcache_addr      = 16'h0200;
    bus.dcache_we_on_req = 1'b0;
    bus.dcache_mem_req   = 1'b1;
    wait_pmem_read("drop");
    @(posedge clk);
    #1;
    bus.dcache_mem_req = 1'b0;
    rc = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.dcache_resp) rc++;
    end
    check("drop resp count", 128'(rc), 128'(0));
    check("drop back to idle", 128'(bus.pmem_read), 128'(0));
    @(posedge clk);
    #1;
    do_req(16'h0200, 1'b0, '0, '0, 1'b1, ref_mem[12'h020], lat);
    check("drop then hit latency", 128'(lat), 128'(0));

    // reset during a fill abandons it; the line misses again afterwards
    bus.dcache_addr    = 16'h00C0;
    bus.dcache_mem_req = 1'b1;
    wait_pmem_read("reset fill");
    #1;
    rst_n = 1'b0;
    #1;
    check("rst fill pmem_read", 128'(bus.pmem_read), 128'(0));
    check("rst fill pmem_write", 128'(bus.pmem_write), 128'(0));
    check("rst fill resp", 128'(bus.dcache_resp), 128'(0));
    bus.dcache_mem_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    f0 = fills;
    do_req(16'h0040, 1'b0, '0, '0, 1'b1, ref_mem[4], lat);
    check("post-reset miss latency", 128'(lat), 128'(LAT+1));
    check("post-reset miss fills", 128'(fills - f0), 128'(1));

    // random stream over 4 tags x 8 sets against the architectural model
    for (int n = 0; n < 300; n++) begin
      a  = lc3b_word'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
      we = ($urandom_range(0, 2) == 0);
      wd = {8{16'($urandom)}};
      be = 16'($urandom);
      if (we) ref_write(a, wd, be);
      do_req(a, we, wd, be, !we, ref_mem[a[15:4]], lat);
    end
    check("pmem read/write exclusive", 128'(both_seen), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
